// File: rtl/array_pkg.sv
// Shared types for the array sequencer: FSM state encoding and the
// instruction codes driven to the systolic array.
package array_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_FETCH,
        S_W_KERNEL,
        S_A_FETCH,
        S_A_EXEC,
        S_DRAIN,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_l0_fetch.sv
// SRAM-to-L0 streamer: issues len reads, writes each returned word into L0
// one cycle later, and stalls both reads and writes while L0 is full.
module sram_l0_fetch #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [CW-1:0] len,
    input  logic          l0_full,
    output logic          rd,
    output logic [CW-1:0] idx,
    output logic          l0_wr,
    output logic          last
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;

    // The SRAM output holds its last word while cen is high, so a pending
    // word survives any number of full cycles; a new read only goes out in
    // a cycle where the pending word is being written.
    always_comb begin
        l0_wr  = pend_q & ~l0_full & en & ~clr;
        rd     = en & ~clr & ~l0_full & (cnt_q != len);
        idx    = cnt_q;
        last   = l0_wr & (cnt_q == len);
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (clr) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (en) begin
            if (rd) begin
                cnt_d  = cnt_q + 1'b1;
                pend_d = 1'b1;
            end else if (l0_wr) begin
                pend_d = 1'b0;
            end
            if (last) cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/array_seq_ctrl.sv
// Sequencer for one convolution pass: per kernel position load weights into
// the array, stream activations, drain OFIFO rows to psum memory, clear.
module array_seq_ctrl
    import array_pkg::*;
#(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int KIJ_MAX = 9,
    parameter int NIJ_MAX = 36,
    parameter int AW      = 7,
    parameter int PAW     = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [3:0]     cfg_kij,
    input  logic [7:0]     cfg_nij,
    output logic           busy,
    output logic           done,
    output logic           act_cen,
    output logic [AW-1:0]  act_addr,
    output logic           w_cen,
    output logic [AW-1:0]  w_addr,
    output logic           sel_w,
    output logic           l0_wr,
    output logic           l0_rd,
    input  logic           l0_full,
    output logic [1:0]     inst_w,
    output logic           w_clr,
    input  logic           ofifo_valid,
    output logic           ofifo_rd,
    output logic           pmem_cen,
    output logic           pmem_wen,
    output logic [PAW-1:0] pmem_addr
);

    localparam int KW = $clog2(KIJ_MAX + 1);
    localparam int NW = $clog2(NIJ_MAX + 1);
    localparam int FW = $clog2(max2(ROW, NIJ_MAX) + 1);
    localparam int TW = $clog2(max2(2 * ROW + COL, NIJ_MAX) + 1);

    state_t        state_q, state_d;
    logic [KW-1:0] kij_q, kij_d;
    logic [KW-1:0] cfg_kij_q, cfg_kij_d;
    logic [NW-1:0] cfg_nij_q, cfg_nij_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          cfg_ok;
    logic          f_en, f_rd, f_wr, f_last;
    logic [FW-1:0] f_len, f_idx;
    logic          kload;
    logic          pop;

    sram_l0_fetch #(.CW(FW)) u_fetch (
        .clk     (clk),
        .reset   (reset),
        .en      (f_en),
        .clr     (abort),
        .len     (f_len),
        .l0_full (l0_full),
        .rd      (f_rd),
        .idx     (f_idx),
        .l0_wr   (f_wr),
        .last    (f_last)
    );

    always_comb begin
        cfg_ok = (cfg_kij != 4'd0) && (32'(cfg_kij) <= 32'(KIJ_MAX)) &&
                 (cfg_nij != 8'd0) && (32'(cfg_nij) <= 32'(NIJ_MAX));
        f_en   = (state_q == S_W_FETCH) || (state_q == S_A_FETCH);
        f_len  = (state_q == S_W_FETCH) ? FW'(ROW) : FW'(cfg_nij_q);
        kload  = (state_q == S_W_KERNEL) && (cnt_q < TW'(ROW));
        pop    = (state_q == S_DRAIN) && ofifo_valid && !abort;
    end

    always_comb begin
        state_d   = state_q;
        kij_d     = kij_q;
        cfg_kij_d = cfg_kij_q;
        cfg_nij_d = cfg_nij_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_kij_d = KW'(cfg_kij);
                    cfg_nij_d = NW'(cfg_nij);
                    kij_d     = '0;
                    cnt_d     = '0;
                    state_d   = cfg_ok ? S_W_FETCH : S_DONE;
                end
            end
            S_W_FETCH: if (f_last) state_d = S_W_KERNEL;
            S_W_KERNEL: begin
                // ROW load cycles followed by ROW+COL cycles for weights to settle
                if (cnt_q == TW'(2 * ROW + COL - 1)) begin
                    cnt_d   = '0;
                    state_d = S_A_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_A_FETCH: if (f_last) state_d = S_A_EXEC;
            S_A_EXEC: begin
                if (cnt_q == TW'(cfg_nij_q) - TW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (pop) begin
                    if (cnt_q == TW'(cfg_nij_q) - TW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_CLEAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (kij_q + KW'(1) < cfg_kij_q) begin
                    kij_d   = kij_q + KW'(1);
                    state_d = S_W_FETCH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            kij_d   = '0;
            cnt_d   = '0;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE) && !abort;
        w_cen     = 1'b1;
        w_addr    = '0;
        act_cen   = 1'b1;
        act_addr  = '0;
        sel_w     = (state_q != S_A_FETCH);
        l0_wr     = f_wr;
        l0_rd     = 1'b0;
        inst_w    = INST_IDLE;
        w_clr     = (state_q == S_CLEAR) || (abort && busy);
        ofifo_rd  = pop;
        pmem_cen  = !pop;
        pmem_wen  = !pop;
        pmem_addr = '0;
        if (f_rd && state_q == S_W_FETCH) begin
            w_cen  = 1'b0;
            w_addr = AW'(kij_q) * AW'(ROW) + AW'(f_idx);
        end
        if (f_rd && state_q == S_A_FETCH) begin
            act_cen  = 1'b0;
            act_addr = AW'(f_idx);
        end
        if (!abort && kload) begin
            l0_rd  = 1'b1;
            inst_w = INST_KLOAD;
        end
        if (!abort && state_q == S_A_EXEC) begin
            l0_rd  = 1'b1;
            inst_w = INST_EXEC;
        end
        if (pop) pmem_addr = PAW'(kij_q) * PAW'(cfg_nij_q) + PAW'(cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            kij_q     <= '0;
            cfg_kij_q <= '0;
            cfg_nij_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            kij_q     <= kij_d;
            cfg_kij_q <= cfg_kij_d;
            cfg_nij_q <= cfg_nij_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_array_seq_ctrl.sv
// Scoreboard bench for array_seq_ctrl: expected SRAM/psum addresses are
// queued per run and popped by a monitor whenever the DUT asserts an access.
module tb_array_seq_ctrl;

    localparam int ROW = 8, COL = 8, KIJ_MAX = 9, NIJ_MAX = 36, AW = 7, PAW = 9;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [3:0] cfg_kij = '0;
    logic [7:0] cfg_nij = '0;
    logic busy, done, act_cen, w_cen, sel_w, l0_wr, l0_rd, w_clr, ofifo_rd;
    logic pmem_cen, pmem_wen;
    logic l0_full = 1'b0, ofifo_valid = 1'b1;
    logic [AW-1:0] act_addr, w_addr;
    logic [PAW-1:0] pmem_addr;
    logic [1:0] inst_w;

    array_seq_ctrl #(.ROW(ROW), .COL(COL), .KIJ_MAX(KIJ_MAX), .NIJ_MAX(NIJ_MAX),
                     .AW(AW), .PAW(PAW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_kij(cfg_kij), .cfg_nij(cfg_nij), .busy(busy), .done(done),
        .act_cen(act_cen), .act_addr(act_addr), .w_cen(w_cen), .w_addr(w_addr),
        .sel_w(sel_w), .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_full(l0_full),
        .inst_w(inst_w), .w_clr(w_clr), .ofifo_valid(ofifo_valid),
        .ofifo_rd(ofifo_rd), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
        .pmem_addr(pmem_addr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int wq[$], aq[$], pq[$];
    int w_rd_cnt, a_rd_cnt, l0_wr_cnt, lw_cnt, pm_cnt, clr_cnt, done_cnt;
    int kload_cnt, exec_cnt, pend, cyc, done_cyc, start_cyc;
    bit full_rand = 0, stall_arm = 0;
    int stall_left = 0, ov_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int a);
        checks++;
        errors++;
        $display("FAIL %s unexpected access at addr %0d, required none", name, a);
    endtask

    task automatic zero_counts();
        w_rd_cnt = 0; a_rd_cnt = 0; l0_wr_cnt = 0; lw_cnt = 0; pm_cnt = 0;
        clr_cnt = 0; done_cnt = 0; kload_cnt = 0; exec_cnt = 0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ctl"}, {busy, done, l0_wr, l0_rd, ofifo_rd, w_clr, inst_w,
                             act_cen, w_cen, pmem_cen, pmem_wen, sel_w}, 13'b0000_0000_11111);
        chk({name, "_addr"}, {act_addr, w_addr, pmem_addr}, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Environment: L0 backpressure and OFIFO availability.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_arm && w_rd_cnt >= 3) begin
            stall_arm  = 0;
            stall_left = 3;
        end
        l0_full = (stall_left > 0) || (full_rand && $urandom_range(0, 2) == 0);
        if (stall_left > 0) stall_left--;
        case (ov_mode)
            0:       ofifo_valid = 1'b1;
            1:       ofifo_valid = ~ofifo_valid;
            default: ofifo_valid = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor
    initial forever begin
        int rds;
        @(negedge clk);
        if (reset) begin
            pend = 0;
        end else if (abort) begin
            chk("abort_outputs_off", {w_cen, act_cen, pmem_cen, pmem_wen, l0_wr, l0_rd,
                                      ofifo_rd, done, inst_w}, 10'b1111_0000_00);
            if (busy) chk("abort_w_clr", w_clr, 1);
            if (w_clr) clr_cnt++;
            pend = 0;
        end else begin
            rds = 0;
            if (!w_cen) begin
                rds++; w_rd_cnt++;
                chk("w_sel", sel_w, 1);
                if (wq.size() == 0) unexpected("w_read", int'(w_addr));
                else chk("w_addr", w_addr, wq.pop_front());
            end
            if (!act_cen) begin
                rds++; a_rd_cnt++;
                chk("act_sel", sel_w, 0);
                if (aq.size() == 0) unexpected("act_read", int'(act_addr));
                else chk("act_addr", act_addr, aq.pop_front());
            end
            if (l0_full) chk("read_while_full", rds, 0);
            // A word read earlier must land in L0 the first cycle L0 is not full.
            if (pend > 0 || l0_wr) chk("l0_wr_timing", l0_wr, (pend > 0 && !l0_full));
            if (l0_wr) begin
                l0_wr_cnt++;
                if (sel_w) lw_cnt++;
            end
            pend = pend + rds - int'(l0_wr);
            if (!pmem_wen || !pmem_cen || ofifo_rd) begin
                pm_cnt++;
                chk("pop_write_pair", {pmem_cen, pmem_wen, ofifo_rd, ofifo_valid}, 4'b0011);
                if (pq.size() == 0) unexpected("pmem_write", int'(pmem_addr));
                else chk("pmem_addr", pmem_addr, pq.pop_front());
            end
            if (w_clr) clr_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (l0_rd && inst_w == 2'b01) kload_cnt++;
            if (l0_rd && inst_w == 2'b10) exec_cnt++;
        end
    end

    task automatic push_model(input int kij, input int nij);
        wq.delete(); aq.delete(); pq.delete();
        for (int k = 0; k < kij; k++) begin
            for (int i = 0; i < ROW; i++) wq.push_back(k * ROW + i);
            for (int i = 0; i < nij; i++) aq.push_back(i);
            for (int j = 0; j < nij; j++) pq.push_back(k * nij + j);
        end
    endtask

    task automatic issue_start(input int kij, input int nij);
        @(posedge clk);
        #1;
        zero_counts();
        cfg_kij   = 4'(kij);
        cfg_nij   = 8'(nij);
        start     = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_seq(input int kij, input int nij, input bit frnd, input int ovm,
                           input bit mid_start, input bit stall);
        bit legal;
        int n;
        legal = (kij >= 1 && kij <= KIJ_MAX && nij >= 1 && nij <= NIJ_MAX);
        if (legal) push_model(kij, nij);
        else push_model(0, 0);
        full_rand = frnd;
        ov_mode   = ovm;
        stall_arm = stall;
        issue_start(kij, nij);
        n = 0;
        while (done_cnt == 0 && n < 6000) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                cfg_kij = 4'($urandom);
                cfg_nij = 8'($urandom);
            end
            start = (mid_start && n == 30);
            n++;
        end
        start = 1'b0;
        full_rand = 0;
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout kij %0d nij %0d, required done within 6000 cycles", kij, nij);
        end
        @(negedge clk);
        chk("idle_after_done", busy, 0);
        chk("done_count", done_cnt, 1);
        chk("w_reads", w_rd_cnt, legal ? kij * ROW : 0);
        chk("act_reads", a_rd_cnt, legal ? kij * nij : 0);
        chk("pmem_writes", pm_cnt, legal ? kij * nij : 0);
        chk("w_clr_pulses", clr_cnt, legal ? kij : 0);
        chk("l0_wr_total", l0_wr_cnt, legal ? kij * (ROW + nij) : 0);
        chk("l0_wr_weights", lw_cnt, legal ? kij * ROW : 0);
        chk("kload_cycles", kload_cnt, legal ? kij * ROW : 0);
        chk("exec_cycles", exec_cnt, legal ? kij * nij : 0);
        chk("queues_drained", wq.size() + aq.size() + pq.size(), 0);
        if (!legal) chk("illegal_done_latency", done_cyc - start_cyc, 1);
    endtask

    initial begin
        int n, nij;
        #3;
        chk_reset_vals("reset_initial");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_seq(9, 36, 0, 0, 0, 0);
        run_seq(1, 4, 0, 0, 0, 1);
        run_seq(1, 4, 0, 1, 0, 0);
        run_seq(3, 20, 1, 2, 1, 0);
        for (int r = 0; r < 4; r++)
            run_seq($urandom_range(1, KIJ_MAX), $urandom_range(1, NIJ_MAX), 1, 2, 0, 0);
        run_seq(10, 4, 0, 0, 0, 0);
        run_seq(0, 4, 0, 0, 0, 0);
        run_seq(3, 0, 0, 0, 0, 0);
        run_seq(3, 37, 0, 0, 0, 0);
        run_seq(KIJ_MAX, NIJ_MAX, 1, 2, 0, 0);

        // start and abort together while idle
        @(posedge clk);
        #1 start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", busy, 0);

        // abort during the activation execute phase of the third kernel position
        nij = $urandom_range(4, 20);
        push_model(3, nij);
        ov_mode = 0;
        issue_start(3, nij);
        n = 0;
        do begin
            @(posedge clk);
            #1 start = 1'b0;
            n++;
        end while (!(clr_cnt == 2 && l0_rd && inst_w == 2'b10) && n < 4000);
        chk("abort_reached_exec", (n < 4000), 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_to_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort_w_clr_total", clr_cnt, 3);
        chk("abort_no_done", done_cnt, 0);
        run_seq(2, 5, 0, 0, 0, 0);

        // asynchronous reset while draining
        push_model(2, 8);
        ov_mode = 2;
        issue_start(2, 8);
        n = 0;
        do begin
            @(posedge clk);
            #1 start = 1'b0;
            n++;
        end while (pm_cnt < 3 && n < 4000);
        chk("drain_reached", (n < 4000), 1);
        #1 reset = 1'b1;
        #1 chk_reset_vals("reset_async");
        wq.delete(); aq.delete(); pq.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        pm_cnt = 0;
        @(negedge clk);
        chk("post_reset_no_write", {pmem_wen, busy}, 2'b10);
        @(negedge clk);
        chk("post_reset_pm_cnt", pm_cnt, 0);
        run_seq(2, 6, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
